// File: rtl/mips_main_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller and the ALU decoder stage.
package mips_main_controller_pkg;

    // Opcodes taken from instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // State encodings, visible on state_dbg
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_RTYPEEX = 4'd6;
    localparam logic [3:0] ST_RTYPEWB = 4'd7;
    localparam logic [3:0] ST_BEQEX   = 4'd8;
    localparam logic [3:0] ST_ADDIEX  = 4'd9;
    localparam logic [3:0] ST_ADDIWB  = 4'd10;
    localparam logic [3:0] ST_JEX     = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_MEMADR  = ST_MEMADR,
        S_MEMRD   = ST_MEMRD,
        S_MEMWB   = ST_MEMWB,
        S_MEMWR   = ST_MEMWR,
        S_RTYPEEX = ST_RTYPEEX,
        S_RTYPEWB = ST_RTYPEWB,
        S_BEQEX   = ST_BEQEX,
        S_ADDIEX  = ST_ADDIEX,
        S_ADDIWB  = ST_ADDIWB,
        S_JEX     = ST_JEX
    } state_e;

    // ALUOp: what the ALU decoder should do
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_controller.sv
// Multi-cycle MIPS main control FSM with a memory-ready stall handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+4 when memory ready
// DECODE   | compute branch target into ALUOut, dispatch on opcode
// MEMADR   | compute load/store address regA + sext(imm)
// MEMRD    | data read at ALUOut, wait for memory ready
// MEMWB    | write MDR to rt
// MEMWR    | data write at ALUOut, strobe held until memory ready
// RTYPEEX  | regA op regB, operation chosen by funct
// RTYPEWB  | write ALUOut to rd
// BEQEX    | regA - regB, load branch target when zero
// ADDIEX   | regA + sext(imm)
// ADDIWB   | write ALUOut to rt
// JEX      | load jump target into PC
// 12..15   | unreachable, recover to FETCH with all enables low
module mips_main_controller
    import mips_main_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state_dbg
);

    state_e r_state;
    state_e w_next;
    logic   w_pcwrite;
    logic   w_branch;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next     = S_FETCH;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                IRWrite   = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SEXT_SH;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
                // Only LW/SW reach here, so anything not SW is a load.
                w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                w_next  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_JEX: begin
                PCSrc     = PCSRC_JUMP;
                w_pcwrite = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign PCEn      = w_pcwrite | (w_branch & zero);
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mips_main_controller.sv
// Self-checking bench for mips_main_controller: directed scenarios plus
// randomized instruction streams with random memory wait states.
module tb_mips_main_controller;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, PCEn, illegal_op, retire;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_main_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .retire(retire), .state_dbg(state_dbg)
    );

    function automatic int b(input logic x);
        return (x === 1'b1) ? 1 : 0;
    endfunction

    function automatic bit is_legal(input logic [5:0] opc);
        return (opc == T_RTYPE) || (opc == T_LW) || (opc == T_SW) ||
               (opc == T_BEQ) || (opc == T_ADDI) || (opc == T_J);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock cycle in which the controller is expected to sit in state st.
    // Expected outputs come from the per-state output table of the controller.
    task automatic step(input int st, input logic rdy, input logic [5:0] opc, output int ret);
        logic z;
        int   e_srcb, e_aluop, e_pcsrc;
        z = 1'($urandom_range(0, 1));
        mem_ready = rdy;
        zero      = z;
        opcode    = opc;
        @(negedge clk);
        e_srcb  = (st == 0) ? 1 : (st == 1) ? 3 : (st == 2 || st == 9) ? 2 : 0;
        e_aluop = (st == 6) ? 2 : (st == 8) ? 1 : 0;
        e_pcsrc = (st == 8) ? 1 : (st == 11) ? 2 : 0;
        chk("state_dbg", int'(state_dbg), st);
        chk("mem_req",   b(mem_req),   b(st == 0 || st == 3 || st == 5));
        chk("IorD",      b(IorD),      b(st == 3 || st == 5));
        chk("MemWrite",  b(MemWrite),  b(st == 5));
        chk("IRWrite",   b(IRWrite),   b(st == 0 && rdy));
        chk("RegDst",    b(RegDst),    b(st == 7));
        chk("MemtoReg",  b(MemtoReg),  b(st == 4));
        chk("RegWrite",  b(RegWrite),  b(st == 4 || st == 7 || st == 10));
        chk("ALUSrcA",   b(ALUSrcA),   b(st == 2 || st == 6 || st == 8 || st == 9));
        chk("ALUSrcB",   int'(ALUSrcB), e_srcb);
        chk("ALUOp",     int'(ALUOp),   e_aluop);
        chk("PCSrc",     int'(PCSrc),   e_pcsrc);
        chk("PCEn",      b(PCEn),      b((st == 0 && rdy) || st == 11 || (st == 8 && z)));
        chk("illegal_op", b(illegal_op), b(st == 1 && !is_legal(opc)));
        chk("retire",    b(retire),
            b(st == 4 || st == 7 || st == 8 || st == 10 || st == 11 || (st == 5 && rdy)));
        ret = b(retire);
        @(posedge clk);
        #1;
    endtask

    // Runs one whole instruction from FETCH: fw stall cycles on fetch,
    // dw stall cycles on the data access. The expected state walk follows
    // the instruction's class; afterwards exactly one retire must have been seen.
    task automatic run_instr(input logic [5:0] opc, input int fw, input int dw);
        int r;
        int rc;
        rc = 0;
        for (int i = 0; i < fw; i++) begin step(0, 1'b0, opc, r); rc += r; end
        step(0, 1'b1, opc, r); rc += r;
        step(1, 1'($urandom_range(0, 1)), opc, r); rc += r;
        case (opc)
            T_LW: begin
                step(2, 1'($urandom_range(0, 1)), opc, r); rc += r;
                for (int i = 0; i < dw; i++) begin step(3, 1'b0, opc, r); rc += r; end
                step(3, 1'b1, opc, r); rc += r;
                step(4, 1'($urandom_range(0, 1)), opc, r); rc += r;
            end
            T_SW: begin
                step(2, 1'($urandom_range(0, 1)), opc, r); rc += r;
                for (int i = 0; i < dw; i++) begin step(5, 1'b0, opc, r); rc += r; end
                step(5, 1'b1, opc, r); rc += r;
            end
            T_RTYPE: begin
                step(6, 1'($urandom_range(0, 1)), opc, r); rc += r;
                step(7, 1'($urandom_range(0, 1)), opc, r); rc += r;
            end
            T_BEQ: begin
                step(8, 1'($urandom_range(0, 1)), opc, r); rc += r;
            end
            T_ADDI: begin
                step(9, 1'($urandom_range(0, 1)), opc, r); rc += r;
                step(10, 1'($urandom_range(0, 1)), opc, r); rc += r;
            end
            T_J: begin
                step(11, 1'($urandom_range(0, 1)), opc, r); rc += r;
            end
            default: ;
        endcase
        chk("retire_count", rc, is_legal(opc) ? 1 : 0);
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] opc;
        int         r;
        legal_ops[0] = T_RTYPE; legal_ops[1] = T_LW;   legal_ops[2] = T_SW;
        legal_ops[3] = T_BEQ;   legal_ops[4] = T_ADDI; legal_ops[5] = T_J;

        // Reset held: FETCH outputs with mem_ready gating
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = T_RTYPE;
        #3;
        chk("rst_state",   int'(state_dbg), 0);
        chk("rst_irwrite", b(IRWrite), 1);
        chk("rst_pcen",    b(PCEn), 1);
        chk("rst_srcb",    int'(ALUSrcB), 1);
        chk("rst_regwr",   b(RegWrite), 0);
        mem_ready = 1'b0;
        #1;
        chk("rst_irwrite_gated", b(IRWrite), 0);
        chk("rst_pcen_gated",    b(PCEn), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed instruction walks
        run_instr(T_LW, 0, 0);
        run_instr(T_SW, 0, 3);
        run_instr(T_BEQ, 0, 0);
        run_instr(T_RTYPE, 1, 0);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_J, 2, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(T_LW, 1, 2);

        // Reset pulsed while a load waits in MEMRD
        step(0, 1'b1, T_LW, r);
        step(1, 1'b1, T_LW, r);
        step(2, 1'b1, T_LW, r);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_pre_state", int'(state_dbg), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_state",  int'(state_dbg), 0);
        chk("abort_regwr",  b(RegWrite), 0);
        chk("abort_memwr",  b(MemWrite), 0);
        @(posedge clk);
        #1;
        chk("abort_hold_state", int'(state_dbg), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(T_RTYPE, 0, 0);

        // Randomized instruction stream with random wait states
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do opc = 6'($urandom); while (is_legal(opc));
            end else begin
                opc = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
